// File: rtl/find_1_pkg.sv
// find_1_pkg: shared types and constants for the streaming set-bit index finder.
// Holds the FSM state enum, the derived-width helper and the default sizes.
package find_1_pkg;

  localparam int DEF_DATA_W = 128;
  localparam int DEF_LANES  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Number of bits needed to encode values 0..n-1 (used for IDX_W and NUM_W).
  function automatic int f1_clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/find_1_lanes.sv
// find_1_lanes: combinational priority extractor. Picks the LANES lowest set
// bits of the mask in ascending order, reports how many were found, whether
// they were the last ones, and which mask bits they occupy.
module find_1_lanes
  import find_1_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int LANES  = DEF_LANES,
  localparam int IDX_W  = f1_clog2(DATA_W),
  localparam int NUM_W  = f1_clog2(LANES + 1)
) (
  input  logic [DATA_W-1:0]      mask,
  output logic [LANES*IDX_W-1:0] idx,
  output logic [NUM_W-1:0]       num,
  output logic                   last,
  output logic [DATA_W-1:0]      clr
);

  logic [NUM_W-1:0] cnt;
  logic             more;

  // Walk the mask from bit 0 up, filling lanes until they run out.
  always_comb begin
    idx  = '0;
    clr  = '0;
    cnt  = '0;
    more = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (mask[i]) begin
        if (int'(cnt) < LANES) begin
          idx[int'(cnt)*IDX_W +: IDX_W] = IDX_W'(i);
          clr[i] = 1'b1;
          cnt    = cnt + NUM_W'(1);
        end else begin
          more = 1'b1;
        end
      end
    end
  end

  assign num  = cnt;
  assign last = ~more;

endmodule

// File: rtl/find_1_idx_stream.sv
// find_1_idx_stream: accepts one bitmap word per handshake and streams out the
// indices of its set bits, LANES per beat, lowest first.
// Optional macro FIND1_ZERO_SKIP_EN: all-zero words are consumed silently
// instead of producing a single empty beat.
module find_1_idx_stream
  import find_1_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int LANES  = DEF_LANES,
  localparam int IDX_W  = f1_clog2(DATA_W),
  localparam int NUM_W  = f1_clog2(LANES + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [DATA_W-1:0]      i_data,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [LANES*IDX_W-1:0] o_idx,
  output logic [NUM_W-1:0]       o_num,
  output logic                   o_last
);

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   mask_p0, mask_nxt;
  logic [LANES*IDX_W-1:0] lane_idx;
  logic [NUM_W-1:0]    lane_num;
  logic                lane_last;
  logic [DATA_W-1:0]   lane_clr;
  logic                out_hs, last_hs, accept;

  find_1_lanes #(
    .DATA_W (DATA_W),
    .LANES  (LANES)
  ) u_lanes (
    .mask (mask_p0),
    .idx  (lane_idx),
    .num  (lane_num),
    .last (lane_last),
    .clr  (lane_clr)
  );

  // Outputs come only from the mask register; gated to zero outside EMIT.
  assign o_out_valid = (state == EMIT);
  assign o_idx       = o_out_valid ? lane_idx : '0;
  assign o_num       = o_out_valid ? lane_num : '0;
  assign o_last      = o_out_valid & lane_last;

  assign out_hs     = o_out_valid & i_out_ready;
  assign last_hs    = out_hs & o_last;
  assign o_in_ready = ~i_rst & ((state == IDLE) | last_hs);
  assign accept     = i_in_valid & o_in_ready;

  // Next-state and next-mask: drain emitted bits, then let a new word override.
  always_comb begin
    state_nxt = state;
    mask_nxt  = mask_p0;
    if (out_hs) begin
      mask_nxt = mask_p0 & ~lane_clr;
      if (o_last) state_nxt = IDLE;
    end
    if (accept) begin
      mask_nxt  = i_data;
      state_nxt = EMIT;
`ifdef FIND1_ZERO_SKIP_EN
      if (i_data == '0) state_nxt = IDLE;
`endif
    end
  end

  // State and mask registers; reset drops any partially emitted word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      mask_p0 <= '0;
    end else begin
      state   <= state_nxt;
      mask_p0 <= mask_nxt;
    end
  end

endmodule

// File: tb/tb_find_1_idx_stream.sv
// Directed self-checking bench for find_1_idx_stream (DATA_W=128, LANES=4).
module tb_find_1_idx_stream;

  localparam int DATA_W = 128;
  localparam int LANES  = 4;
  localparam int IDX_W  = 7;
  localparam int NUM_W  = 3;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_W-1:0]      data;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*IDX_W-1:0] idx;
  logic [NUM_W-1:0]       num;
  logic                   last;

  int n_chk;
  int n_pass;

  find_1_idx_stream #(
    .DATA_W (DATA_W),
    .LANES  (LANES)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_data      (data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_idx       (idx),
    .o_num       (num),
    .o_last      (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [LANES*IDX_W-1:0] pk(input int a, input int b, input int c, input int d);
    return {IDX_W'(d), IDX_W'(c), IDX_W'(b), IDX_W'(a)};
  endfunction

  function automatic logic [DATA_W-1:0] bits(input int a, input int b, input int c, input int d,
                                             input int e, input int f);
    logic [DATA_W-1:0] w;
    w = '0;
    if (a >= 0) w[a] = 1'b1;
    if (b >= 0) w[b] = 1'b1;
    if (c >= 0) w[c] = 1'b1;
    if (d >= 0) w[d] = 1'b1;
    if (e >= 0) w[e] = 1'b1;
    if (f >= 0) w[f] = 1'b1;
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w);
    in_valid = 1'b1;
    data     = w;
    step();
    in_valid = 1'b0;
    data     = '0;
  endtask

  task automatic chk_beat(input string tag, input logic [LANES*IDX_W-1:0] e_idx,
                          input int e_num, input logic e_last);
    chk({tag, "_valid"}, 128'(out_valid), 128'(1));
    chk({tag, "_idx"},   128'(idx),       128'(e_idx));
    chk({tag, "_num"},   128'(num),       128'(e_num));
    chk({tag, "_last"},  128'(last),      128'(e_last));
  endtask

  initial begin
    logic [DATA_W-1:0] w;
    n_chk     = 0;
    n_pass    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    data      = '0;
    out_ready = 1'b1;

    // Reset state
    step();
    step();
    @(negedge clk);
    chk("rst_in_ready",  128'(in_ready),  128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_idx",       128'(idx),       128'(0));
    chk("rst_num",       128'(num),       128'(0));
    chk("rst_last",      128'(last),      128'(0));
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 128'(in_ready),  128'(1));
    chk("post_rst_valid",    128'(out_valid), 128'(0));
    step();

    // Four ones: single beat
    send_word(bits(3, 17, 64, 127, -1, -1));
    @(negedge clk);
    chk_beat("w4", pk(3, 17, 64, 127), 4, 1'b1);
    step();
    @(negedge clk);
    chk("w4_done_valid", 128'(out_valid), 128'(0));
    step();

    // Six ones with 3 cycles of backpressure on beat 1
    out_ready = 1'b0;
    send_word(bits(0, 1, 2, 5, 9, 100));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_beat("w6_stall", pk(0, 1, 2, 5), 4, 1'b0);
      chk("w6_stall_in_ready", 128'(in_ready), 128'(0));
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk_beat("w6_b1", pk(0, 1, 2, 5), 4, 1'b0);
    chk("w6_b1_in_ready", 128'(in_ready), 128'(0));
    step();
    @(negedge clk);
    chk_beat("w6_b2", pk(9, 100, 0, 0), 2, 1'b1);
    chk("w6_b2_in_ready", 128'(in_ready), 128'(1));
    step();
    @(negedge clk);
    chk("w6_done_valid", 128'(out_valid), 128'(0));
    step();

    // Back-to-back words, no bubble
    in_valid = 1'b1;
    data     = bits(0, -1, -1, -1, -1, -1);
    step();
    data     = bits(127, -1, -1, -1, -1, -1);
    @(negedge clk);
    chk_beat("b2b_1", pk(0, 0, 0, 0), 1, 1'b1);
    chk("b2b_1_in_ready", 128'(in_ready), 128'(1));
    step();
    in_valid = 1'b0;
    data     = '0;
    @(negedge clk);
    chk_beat("b2b_2", pk(127, 0, 0, 0), 1, 1'b1);
    step();
    @(negedge clk);
    chk("b2b_done_valid", 128'(out_valid), 128'(0));
    step();

    // All-zero word
    send_word('0);
    @(negedge clk);
`ifdef FIND1_ZERO_SKIP_EN
    chk("zero_valid",    128'(out_valid), 128'(0));
    chk("zero_in_ready", 128'(in_ready),  128'(1));
`else
    chk_beat("zero", pk(0, 0, 0, 0), 0, 1'b1);
    step();
    @(negedge clk);
    chk("zero_done_valid", 128'(out_valid), 128'(0));
`endif
    step();

    // Reset in the middle of an all-ones word
    w = '1;
    send_word(w);
    @(negedge clk);
    chk_beat("ones_b1", pk(0, 1, 2, 3), 4, 1'b0);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", 128'(in_ready), 128'(0));
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid",    128'(out_valid), 128'(0));
    chk("mid_rst_idx",      128'(idx),       128'(0));
    chk("mid_rst_num",      128'(num),       128'(0));
    chk("mid_rst_in_ready", 128'(in_ready),  128'(1));
    step();
    send_word(128'h10);
    @(negedge clk);
    chk_beat("after_rst", pk(4, 0, 0, 0), 1, 1'b1);
    step();
    @(negedge clk);
    chk("after_rst_done_valid", 128'(out_valid), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/find_1_idx_stream.md
# find_1_idx_stream

Streaming, parametrised successor to the combinational four-index set-bit finder. It accepts one DATA_W-bit word per valid/ready handshake and emits the indices of every set bit, LANES indices per output beat, lowest index first. Each word spans as many beats as it needs. It sits between the bitmap producer and the index-consuming datapath, so a word with more than LANES ones is no longer truncated.

## Interface
- DATA_W, 128: input word width; power of two, 8..1024.
- LANES, 4: index slots per output beat; 1..8.
- IDX_W, $clog2(DATA_W): index width. Derived; not overridable.
- NUM_W, $clog2(LANES+1): beat-count width. Derived.
- i_clk  in  1  clock; all logic on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_in_valid  in  1  input word valid.
- o_in_ready  out  1  block can accept a word this cycle.
- i_data  in  DATA_W  bitmap word; bit 0 is index 0.
- o_out_valid  out  1  output beat valid.
- i_out_ready  in  1  consumer accepts the beat.
- o_idx  out  LANES*IDX_W  lane k is bits [k*IDX_W +: IDX_W]; lane 0 holds the lowest remaining index.
- o_num  out  NUM_W  number of valid lanes in this beat, 0..LANES.
- o_last  out  1  this beat finishes the current word.

## Operation
- The FSM has two states, IDLE and EMIT. It holds a registered DATA_W-bit mask of the set bits not yet emitted.
- In IDLE, o_in_ready=1. When i_in_valid is high, the block latches i_data into the mask and moves to EMIT.
- In EMIT, o_out_valid=1:
  - Lanes 0..o_num-1 hold the o_num lowest set bits of the mask, in ascending order.
  - Unused lanes are driven to 0.
  - o_num = min(popcount(mask), LANES).
  - o_last=1 when popcount(mask) ≤ LANES.
- When a beat is handshaken (o_out_valid & i_out_ready):
  - the emitted bits are cleared from the mask;
  - if o_last was high, the FSM returns to IDLE, or reloads directly (see back-to-back).
- All-zero word: one beat with o_num=0, all lanes 0, o_last=1.
- Back-to-back: o_in_ready is also high when o_out_valid & o_last & i_out_ready. If i_in_valid is high in that cycle, the new word loads and the FSM stays in EMIT.
- While o_out_valid=1 and i_out_ready=0, o_idx, o_num and o_last hold stable.
- The mask is the only storage. The outputs are combinational from the mask register, with no combinational path from i_data to any output. o_in_ready does depend combinationally on i_out_ready.

## Timing
- Reset values: state=IDLE, mask=0, o_out_valid=0, o_idx=0, o_num=0, o_last=0.
- o_in_ready=0 during any cycle with i_rst high, and 1 in the first cycle after reset.
- Latency: a word accepted at edge T gives its first beat valid in the cycle after T.
- Beats per word = max(1, ceil(popcount/LANES)).
- Throughput: one beat per cycle. Words with ≤LANES ones sustain one word per cycle.
- If reset is asserted mid-word, the remaining indices are discarded and nothing partial is emitted afterwards.
- A simultaneous last-beat handshake and input handshake loads the new word; no bubble is inserted.

## Configuration
- Macro: FIND1_ZERO_SKIP_EN.
- Defined:
  - an all-zero word is accepted and consumed silently, with no output beat;
  - the FSM stays in IDLE, or goes to IDLE after a back-to-back reload of a zero word;
  - o_num is never 0 while o_out_valid=1.
- Undefined: the single empty beat described under Operation is emitted.

## Structure
- Package find_1_pkg holds:
  - the state enum (IDLE, EMIT);
  - a function computing IDX_W and NUM_W from the parameters;
  - the default DATA_W and LANES constants.
- Sub-module find_1_lanes: parametrised combinational priority extractor.
  - Inputs: mask.
  - Outputs: LANES indices, a count, and the cleared-bit mask (the emitted bits to clear).
  - It is instantiated once. The top level holds only the FSM, the mask register and the handshake.

## Test plan
- DATA_W=128, LANES=4:
  - i_data = bits {3,17,64,127}, i_out_ready=1 → one beat: idx 3,17,64,127; o_num=4; o_last=1; valid one cycle after acceptance.
  - i_data = bits {0,1,2,5,9,100} → beat 1: 0,1,2,5, num 4, last 0. Beat 2: 9,100,0,0, num 2, last 1.
- Backpressure: as above with i_out_ready low for 3 cycles on beat 1 → outputs stable, o_in_ready=0 throughout; beat 2 follows the release cycle.
- Back-to-back words 0x1 then 0x8000…0, i_in_valid held high → beats idx 0 and idx 127 in consecutive cycles, no bubble.
- Zero word: without the macro → one beat num=0, last=1. With FIND1_ZERO_SKIP_EN → no beat, o_in_ready high in the next cycle.
- Assert i_rst in the cycle after beat 1 of all-ones → o_out_valid=0 and mask cleared after that edge; a following word 0x10 yields idx 4 only.
